button_event_gen: RTL and testbench

Converts the six debounced button levels into a stream of discrete button events with typematic auto-repeat: press, repeat while held, and release. It sits directly downstream of the button debouncer and feeds the game controller and the NN-agent input mux. Events leave through a valid/ready queue, so a stalled consumer loses no events up to the queue depth.

---
 rtl/flappy_btn_pkg.sv | 34 +++
 rtl/btn_evt_fifo.sv | 48 ++++
 rtl/button_event_gen.sv | 180 ++++++++++++++++++
 tb/tb_button_event_gen.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/flappy_btn_pkg.sv
// Shared types for the button event path: event encoding, queue entry layout
// and the per-button typematic state.
package flappy_btn_pkg;

    localparam int NUM_BTN   = 6;
    localparam int BTN_IDX_W = 3;

    // Bit positions of the three pending flags kept per button
    localparam int PEND_PRESS   = 0;
    localparam int PEND_REPEAT  = 1;
    localparam int PEND_RELEASE = 2;

    typedef enum logic [1:0] {
        EVT_PRESS   = 2'b01,
        EVT_RELEASE = 2'b10,
        EVT_REPEAT  = 2'b11
    } btn_evt_e;

    typedef struct packed {
        btn_evt_e               evt_type;
        logic [BTN_IDX_W-1:0]   idx;
    } btn_evt_t;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT
    } btn_fsm_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_evt_fifo.sv
// Small synchronous event queue; the head is read straight from storage so a
// pushed entry is visible the cycle after the push.
module btn_evt_fifo
    import flappy_btn_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset_n,
    input  logic     push,
    input  btn_evt_t din,
    output logic     full,
    input  logic     pop,
    output btn_evt_t dout,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    btn_evt_t    mem_q [DEPTH];
    logic        do_push;
    logic        do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/button_event_gen.sv
// Turns debounced button levels into PRESS / REPEAT / RELEASE events with
// typematic auto-repeat, queued behind a valid/ready interface.
module button_event_gen
    import flappy_btn_pkg::*;
#(
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] btn_level,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [1:0] evt_type,
    output logic [2:0] evt_btn,
    output logic [5:0] held,
    output logic [7:0] dropped_cnt
);

    localparam int CNT_W = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [3*NUM_BTN-1:0] pend_flat;
    logic [3*NUM_BTN-1:0] clr_flat;
    logic [NUM_BTN-1:0]   drop_vec;

    logic                 sel_valid;
    logic [BTN_IDX_W-1:0] sel_btn;
    logic [2:0]           sel_bit;
    btn_evt_e             sel_type;
    logic                 fifo_push;
    logic                 fifo_full;
    logic                 fifo_empty;
    btn_evt_t             fifo_din;
    btn_evt_t             fifo_dout;

    logic [3:0]           drop_sum;
    logic [8:0]           drop_acc;
    logic [7:0]           dropped_d;
    logic [7:0]           dropped_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            btn_fsm_e         state_q;
            logic [CNT_W-1:0] cnt_q;
            logic [2:0]       pend_q;
            logic [2:0]       new_evt;
            logic [2:0]       clr;

            assign clr = clr_flat[3*gi +: 3];

            // Release wins over counter expiry in the same cycle
            always_comb begin
                new_evt = 3'b000;
                case (state_q)
                    IDLE:   if (btn_level[gi]) new_evt[PEND_PRESS] = 1'b1;
                    HOLD:   if (!btn_level[gi])           new_evt[PEND_RELEASE] = 1'b1;
                            else if (cnt_q == DELAY_LAST) new_evt[PEND_REPEAT]  = 1'b1;
                    REPEAT: if (!btn_level[gi])            new_evt[PEND_RELEASE] = 1'b1;
                            else if (cnt_q == PERIOD_LAST) new_evt[PEND_REPEAT]  = 1'b1;
                    default: new_evt = 3'b000;
                endcase
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end else begin
                    case (state_q)
                        IDLE: begin
                            if (btn_level[gi]) begin
                                state_q <= HOLD;
                                cnt_q   <= '0;
                            end
                        end
                        HOLD: begin
                            if (!btn_level[gi]) begin
                                state_q <= IDLE;
                            end else if (cnt_q == DELAY_LAST) begin
                                state_q <= REPEAT;
                                cnt_q   <= '0;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                        REPEAT: begin
                            if (!btn_level[gi]) begin
                                state_q <= IDLE;
                            end else if (cnt_q == PERIOD_LAST) begin
                                cnt_q <= '0;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                        default: state_q <= IDLE;
                    endcase
                end
            end

            // A flag cleared by this cycle's push may be re-armed without loss
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) pend_q <= 3'b000;
                else          pend_q <= (pend_q & ~clr) | new_evt;
            end

            assign drop_vec[gi]          = |(new_evt & pend_q & ~clr);
            assign pend_flat[3*gi +: 3]  = pend_q;
            assign held[gi]              = (state_q != IDLE);
        end
    endgenerate

    // Lowest button index wins; scanning downwards leaves the lowest selected
    always_comb begin
        sel_valid = 1'b0;
        sel_btn   = '0;
        sel_bit   = 3'b000;
        sel_type  = EVT_PRESS;
        for (int b = NUM_BTN - 1; b >= 0; b--) begin
            if (|pend_flat[3*b +: 3]) begin
                sel_valid = 1'b1;
                sel_btn   = BTN_IDX_W'(b);
                if (pend_flat[3*b + PEND_PRESS]) begin
                    sel_bit  = 3'b001;
                    sel_type = EVT_PRESS;
                end else if (pend_flat[3*b + PEND_REPEAT]) begin
                    sel_bit  = 3'b010;
                    sel_type = EVT_REPEAT;
                end else begin
                    sel_bit  = 3'b100;
                    sel_type = EVT_RELEASE;
                end
            end
        end
    end

    assign fifo_push         = sel_valid & ~fifo_full;
    assign fifo_din.evt_type = sel_type;
    assign fifo_din.idx      = sel_btn;

    always_comb begin
        clr_flat = '0;
        if (fifo_push) clr_flat[3*int'(sel_btn) +: 3] = sel_bit;
    end

    btn_evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .din     (fifo_din),
        .full    (fifo_full),
        .pop     (evt_ready),
        .dout    (fifo_dout),
        .empty   (fifo_empty)
    );

    // Several buttons can lose an event in the same cycle; count each one
    always_comb begin
        drop_sum = 4'd0;
        for (int b = 0; b < NUM_BTN; b++) drop_sum = drop_sum + {3'b000, drop_vec[b]};
        drop_acc  = {1'b0, dropped_q} + {5'b00000, drop_sum};
        dropped_d = drop_acc[8] ? 8'hFF : drop_acc[7:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) dropped_q <= 8'd0;
        else          dropped_q <= dropped_d;
    end

    assign evt_valid   = ~fifo_empty;
    assign evt_type    = fifo_empty ? 2'b00 : fifo_dout.evt_type;
    assign evt_btn     = fifo_empty ? 3'b000 : fifo_dout.idx;
    assign dropped_cnt = dropped_q;

endmodule

// File: tb/tb_button_event_gen.sv
// Randomized bench: a timeline-based reference model feeds a scoreboard queue
// that an independent monitor drains against the DUT's event stream.
module tb_button_event_gen;

    localparam int D     = 8;
    localparam int P     = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] btn_level = 6'd0;
    logic       evt_valid;
    logic       evt_ready = 1'b0;
    logic [1:0] evt_type;
    logic [2:0] evt_btn;
    logic [5:0] held;
    logic [7:0] dropped_cnt;

    always #5 clk = ~clk;

    button_event_gen #(
        .REPEAT_DELAY  (D),
        .REPEAT_PERIOD (P),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .btn_level   (btn_level),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_type    (evt_type),
        .evt_btn     (evt_btn),
        .held        (held),
        .dropped_cnt (dropped_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int btn;
        int typ;
    } ev_t;

    ev_t expq[$];

    // Reference model state: whether each button is down, when it went down,
    // which event kinds await the queue (0 press, 1 repeat, 2 release).
    bit   m_down  [6];
    int   m_tpress[6];
    bit   m_pend  [6][3];
    int   m_cnt   = 0;
    int   m_drop  = 0;
    int   m_cyc   = 0;
    int   pb, pk, nk, el, pre_cnt;
    ev_t  pe;

    task automatic chk(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int model_held();
        int v = 0;
        for (int b = 0; b < 6; b++) if (m_down[b]) v |= (1 << b);
        return v;
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            for (int b = 0; b < 6; b++) begin
                m_down[b]   = 1'b0;
                m_tpress[b] = 0;
                for (int k = 0; k < 3; k++) m_pend[b][k] = 1'b0;
            end
            m_cnt  = 0;
            m_drop = 0;
            expq.delete();
        end else begin
            m_cyc++;
            pre_cnt = m_cnt;
            pb = -1;
            pk = -1;
            if (pre_cnt < DEPTH) begin
                for (int b = 0; b < 6; b++) begin
                    if (pb < 0) begin
                        if (m_pend[b][0])      begin pb = b; pk = 0; end
                        else if (m_pend[b][1]) begin pb = b; pk = 1; end
                        else if (m_pend[b][2]) begin pb = b; pk = 2; end
                    end
                end
            end
            if (pb >= 0) begin
                pe.btn = pb;
                pe.typ = (pk == 0) ? 1 : (pk == 1) ? 3 : 2;
                expq.push_back(pe);
                m_pend[pb][pk] = 1'b0;
                m_cnt++;
            end
            if (pre_cnt > 0 && evt_ready) m_cnt--;

            for (int b = 0; b < 6; b++) begin
                nk = -1;
                if (!m_down[b] && btn_level[b]) begin
                    m_down[b]   = 1'b1;
                    m_tpress[b] = m_cyc;
                    nk = 0;
                end else if (m_down[b] && !btn_level[b]) begin
                    m_down[b] = 1'b0;
                    nk = 2;
                end else if (m_down[b]) begin
                    el = m_cyc - m_tpress[b];
                    if (el >= D && ((el - D) % P) == 0) nk = 1;
                end
                if (nk >= 0) begin
                    if (m_pend[b][nk]) begin
                        if (m_drop < 255) m_drop++;
                    end else begin
                        m_pend[b][nk] = 1'b1;
                    end
                end
            end
        end
    end

    // Monitor: compares the DUT's presented head against the scoreboard.
    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rst_valid",   int'(evt_valid),   0);
            chk("rst_type",    int'(evt_type),    0);
            chk("rst_btn",     int'(evt_btn),     0);
            chk("rst_held",    int'(held),        0);
            chk("rst_dropped", int'(dropped_cnt), 0);
        end else begin
            chk("valid",   int'(evt_valid),   (expq.size() != 0) ? 1 : 0);
            chk("held",    int'(held),        model_held());
            chk("dropped", int'(dropped_cnt), m_drop);
            if (evt_valid && expq.size() != 0) begin
                chk("head_type", int'(evt_type), expq[0].typ);
                chk("head_btn",  int'(evt_btn),  expq[0].btn);
                if (evt_ready) begin
                    pe = expq.pop_front();
                    $display("[TB] event btn=%0d type=%0d t=%0t", pe.btn, pe.typ, $time);
                end
            end
        end
    end

    task automatic step_random(input int cycles, input int toggle_odds, input int ready_pct);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #2;
            for (int b = 0; b < 6; b++)
                if ($urandom_range(0, toggle_odds - 1) == 0) btn_level[b] = ~btn_level[b];
            evt_ready = ($urandom_range(0, 99) < ready_pct);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b1;

        // Long holds with mostly-ready consumer to exercise repeats and ordering
        step_random(600, 30, 90);

        // Simultaneous rises on several buttons
        @(posedge clk); #2; btn_level = 6'd0; evt_ready = 1'b1;
        repeat (20) @(posedge clk);
        #2; btn_level = 6'b101010;
        step_random(40, 1000000, 100);

        // Stalled consumer with rapid taps: queue fills, drops saturate
        @(posedge clk); #2; evt_ready = 1'b0;
        for (int c = 0; c < 120; c++) begin
            @(posedge clk);
            #2;
            btn_level = ~btn_level;
        end
        @(negedge clk);
        chk("drop_saturated", int'(dropped_cnt), 255);
        chk("stalled_valid",  int'(evt_valid),   1);

        // Drain with random readiness
        step_random(150, 8, 70);

        // Fill the queue, then reset asynchronously mid-stream
        @(posedge clk); #2; evt_ready = 1'b0; btn_level = 6'h3F;
        repeat (10) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_rst_valid",   int'(evt_valid),   0);
        chk("async_rst_held",    int'(held),        0);
        chk("async_rst_dropped", int'(dropped_cnt), 0);
        @(posedge clk);
        #2;
        reset_n   = 1'b1;
        evt_ready = 1'b1;
        // Levels still high out of reset must each produce a PRESS
        repeat (20) @(posedge clk);
        step_random(100, 20, 80);

        @(posedge clk); #2; evt_ready = 1'b1; btn_level = 6'd0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("final_empty", int'(evt_valid), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
